// File: rtl/perf_pkg.sv
// Shared types and constants for the UUT performance monitor.
// Record layout helper keeps byte ordering in one place.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SEND
  } state_e;

  localparam int REC_LEN      = 12;
  localparam logic [7:0] REC_MAGIC = 8'hA5;
  localparam int STAT_TIMEOUT = 0;

  localparam int N_BLOCK_SIZE_DEF    = 32;
  localparam int SCLK_SPEED_SIZE_DEF = 4;
  localparam int CMD18_SIZE_DEF      = 1;
  localparam logic [31:0] TIMEOUT_DEF = 32'hFFFF_FFFE;

  typedef logic [REC_LEN-1:0][7:0] rec_t;

  // Multi-byte fields go out most significant byte first.
  function automatic rec_t build_rec(
    input logic [7:0]  status,
    input logic [31:0] nblk,
    input logic [7:0]  spd,
    input logic [7:0]  cmd,
    input logic [31:0] cyc
  );
    rec_t r;
    r[0]  = REC_MAGIC;
    r[1]  = status;
    r[2]  = nblk[31:24];
    r[3]  = nblk[23:16];
    r[4]  = nblk[15:8];
    r[5]  = nblk[7:0];
    r[6]  = spd;
    r[7]  = cmd;
    r[8]  = cyc[31:24];
    r[9]  = cyc[23:16];
    r[10] = cyc[15:8];
    r[11] = cyc[7:0];
    return r;
  endfunction

endpackage

// File: rtl/perf_record_serializer.sv
// Holds one 12-byte result record and streams it out
// over a valid/ack handshake with registered outputs.
module perf_record_serializer
  import perf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  rec_t       rec_i,
  input  logic       rec_ack_i,
  output logic       rec_valid_o,
  output logic [7:0] rec_byte_o,
  output logic       rec_last_o,
  output logic       done_o
);

  rec_t       rec_q;
  logic [3:0] idx_q;
  logic [3:0] idx_nxt;
  logic       valid_q;
  logic [7:0] byte_q;
  logic       last_q;

  assign idx_nxt     = idx_q + 4'd1;
  assign rec_valid_o = valid_q;
  assign rec_byte_o  = byte_q;
  assign rec_last_o  = last_q;
  assign done_o      = valid_q & rec_ack_i & last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      rec_q   <= rec_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
      byte_q  <= rec_i[0];
      last_q  <= 1'b0;
    end else if (valid_q && rec_ack_i) begin
      if (last_q) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
        byte_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        idx_q  <= idx_nxt;
        byte_q <= rec_q[idx_nxt];
        last_q <= (idx_nxt == 4'(REC_LEN - 1));
      end
    end
  end

endmodule

// File: rtl/uut_perf_monitor.sv
// Measures UUT run length between start and finish and
// emits a fixed-format result record per run.
module uut_perf_monitor
  import perf_pkg::*;
#(
  parameter int N_BLOCK_SIZE    = N_BLOCK_SIZE_DEF,
  parameter int SCLK_SPEED_SIZE = SCLK_SPEED_SIZE_DEF,
  parameter int CMD18_SIZE      = CMD18_SIZE_DEF,
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uut_start,
  input  logic                       uut_finish,
  input  logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
  input  logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
  input  logic [CMD18_SIZE-1:0]      uut_cmd18,
  output logic                       rec_valid,
  output logic [7:0]                 rec_byte,
  output logic                       rec_last,
  input  logic                       rec_ack,
  output logic                       busy,
  output logic [15:0]                run_count
);

  state_e                     state_q;
  logic [31:0]                cnt_q;
  logic [N_BLOCK_SIZE-1:0]    nblk_q;
  logic [SCLK_SPEED_SIZE-1:0] spd_q;
  logic [CMD18_SIZE-1:0]      cmd_q;
  logic [15:0]                run_count_q;

  logic        to_hit;
  logic        load;
  logic        done;
  logic [7:0]  status_d;
  logic [31:0] cycles_d;
  rec_t        rec_d;

  // Finish has priority over a timeout landing on the same cycle.
  always_comb begin
    to_hit   = (cnt_q == TIMEOUT_CYCLES);
    load     = (state_q == ST_RUN) && (uut_finish || to_hit);
    status_d = '0;
    status_d[STAT_TIMEOUT] = !uut_finish;
    cycles_d = uut_finish ? cnt_q : TIMEOUT_CYCLES;
    rec_d    = build_rec(status_d, 32'(nblk_q),
                         8'(spd_q), 8'(cmd_q), cycles_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nblk_q      <= '0;
      spd_q       <= '0;
      cmd_q       <= '0;
      run_count_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (uut_start) begin
            nblk_q  <= uut_n_blocks;
            spd_q   <= uut_sclk_speed;
            cmd_q   <= uut_cmd18;
            cnt_q   <= 32'd1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load) state_q <= ST_SEND;
          else      cnt_q   <= cnt_q + 32'd1;
        end
        ST_SEND: begin
          if (done) begin
            run_count_q <= run_count_q + 16'd1;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign run_count = run_count_q;

  perf_record_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .rec_i      (rec_d),
    .rec_ack_i  (rec_ack),
    .rec_valid_o(rec_valid),
    .rec_byte_o (rec_byte),
    .rec_last_o (rec_last),
    .done_o     (done)
  );

endmodule

// File: tb/tb_uut_perf_monitor.sv
// Scoreboard bench: two monitor instances (default and
// short-timeout) share one stimulus set selected by sel.
module tb_uut_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] nblk = '0;
  logic [7:0]  spd = '0;
  logic [7:0]  cmd = '0;

  logic        a_v, a_l, a_busy;
  logic [7:0]  a_b;
  logic [15:0] a_cnt;
  logic        b_v, b_l, b_busy;
  logic [7:0]  b_b;
  logic [15:0] b_cnt;

  logic        v, l, bsy;
  logic [7:0]  by;
  logic [15:0] cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_a = 0;
  int exp_b = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uut_perf_monitor dut_a (
    .clk           (clk),
    .rst           (rst),
    .uut_start     (start & ~sel),
    .uut_finish    (finish & ~sel),
    .uut_n_blocks  (nblk),
    .uut_sclk_speed(spd[3:0]),
    .uut_cmd18     (cmd[0:0]),
    .rec_valid     (a_v),
    .rec_byte      (a_b),
    .rec_last      (a_l),
    .rec_ack       (ack & ~sel),
    .busy          (a_busy),
    .run_count     (a_cnt)
  );

  uut_perf_monitor #(
    .N_BLOCK_SIZE   (16),
    .SCLK_SPEED_SIZE(8),
    .CMD18_SIZE     (8),
    .TIMEOUT_CYCLES (32'd50)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .uut_start     (start & sel),
    .uut_finish    (finish & sel),
    .uut_n_blocks  (nblk[15:0]),
    .uut_sclk_speed(spd),
    .uut_cmd18     (cmd),
    .rec_valid     (b_v),
    .rec_byte      (b_b),
    .rec_last      (b_l),
    .rec_ack       (ack & sel),
    .busy          (b_busy),
    .run_count     (b_cnt)
  );

  assign v   = sel ? b_v    : a_v;
  assign by  = sel ? b_b    : a_b;
  assign l   = sel ? b_l    : a_l;
  assign bsy = sel ? b_busy : a_busy;
  assign cnt = sel ? b_cnt  : a_cnt;

  task automatic push_rec(input logic [7:0] st,
                          input logic [31:0] cyc);
    logic [31:0] n;
    logic [7:0]  s;
    logic [7:0]  c;
    n = sel ? {16'h0, nblk[15:0]} : nblk;
    s = sel ? spd : {4'h0, spd[3:0]};
    c = sel ? cmd : {7'h0, cmd[0]};
    q.push_back(8'hA5);
    q.push_back(st);
    q.push_back(n[31:24]);
    q.push_back(n[23:16]);
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    q.push_back(s);
    q.push_back(c);
    q.push_back(cyc[31:24]);
    q.push_back(cyc[23:16]);
    q.push_back(cyc[15:8]);
    q.push_back(cyc[7:0]);
  endtask

  // fin_after == 0 means finish is never raised.
  task automatic do_run(input logic [31:0] n,
                        input logic [7:0] s,
                        input logic [7:0] c,
                        input int fin_after,
                        input bit restart);
    int w;
    nblk = n;
    spd  = s;
    cmd  = c;
    if (fin_after == 0) push_rec(8'h01, 32'd50);
    else push_rec(8'h00, 32'(fin_after));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (restart) begin
      nblk = ~n;
      spd  = ~s;
      cmd  = ~c;
    end
    if (fin_after > 0) begin
      for (int i = 1; i < fin_after; i++) begin
        start = restart && (i == 3);
        @(posedge clk); #1;
      end
      start  = 1'b0;
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
    end else begin
      w = 0;
      while (!v && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      n_chk++;
      if (!v) begin
        n_fail++;
        $display("FAIL wait_valid: got %b expected 1", v);
      end
    end
  endtask

  // mode 0: ack always high, mode 1: ~30% random ack.
  task automatic recv(input int mode, input bit restart,
                      input int exp_cnt);
    int  cyc;
    int  first;
    bit  done;
    logic el;
    cyc = 0;
    first = -1;
    done = 0;
    while (!done && cyc < 400) begin
      ack = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      start = restart && (cyc == 3);
      if (v) begin
        if (first < 0) first = cyc;
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_byte: got %h expected none", by);
          done = 1;
        end else begin
          el = (q.size() == 1);
          if (by !== q[0] || l !== el) begin
            n_fail++;
            $display("FAIL rec_byte: got %h/%b expected %h/%b",
                     by, l, q[0], el);
          end
          if (ack) begin
            void'(q.pop_front());
            if (q.size() == 0) done = 1;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    ack = 1'b0;
    start = 1'b0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL rec_done: got %0d left expected 0", q.size());
    end
    if (mode == 0) begin
      n_chk++;
      if (cyc - first != 12) begin
        n_fail++;
        $display("FAIL burst_len: got %0d expected 12",
                 cyc - first);
      end
    end
    n_chk++;
    if (v !== 1'b0 || bsy !== 1'b0 || cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL post_rec: got v=%b busy=%b cnt=%0d expected 0 0 %0d",
               v, bsy, cnt, exp_cnt);
    end
  endtask

  task automatic chk_reset(input string nm);
    n_chk++;
    if (a_v !== 1'b0 || a_b !== 8'h00 || a_l !== 1'b0 ||
        a_busy !== 1'b0 || a_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL %s_a: got v=%b b=%h l=%b busy=%b cnt=%0d expected zeros",
               nm, a_v, a_b, a_l, a_busy, a_cnt);
    end
    n_chk++;
    if (b_v !== 1'b0 || b_b !== 8'h00 || b_l !== 1'b0 ||
        b_busy !== 1'b0 || b_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL %s_b: got v=%b b=%h l=%b busy=%b cnt=%0d expected zeros",
               nm, b_v, b_b, b_l, b_busy, b_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    ack = 1'b1;
    do_run(32'h0001_0203, 8'h09, 8'h01, 1000, 1'b0);
    exp_a++;
    recv(0, 1'b0, exp_a);
  endtask

  task automatic test_consecutive();
    sel = 1'b0;
    do_run(32'hDEAD_BEEF, 8'h0F, 8'h00, 1, 1'b0);
    exp_a++;
    recv(0, 1'b0, exp_a);
  endtask

  task automatic test_random_ack();
    sel = 1'b0;
    do_run(32'h0001_0203, 8'h09, 8'h01, 1000, 1'b0);
    exp_a++;
    recv(1, 1'b0, exp_a);
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    do_run(32'h0000_1234, 8'hC3, 8'h12, 0, 1'b0);
    exp_b++;
    recv(0, 1'b0, exp_b);
  endtask

  task automatic test_timeout_tie();
    sel = 1'b1;
    do_run(32'h0000_0040, 8'h55, 8'h12, 50, 1'b0);
    exp_b++;
    recv(0, 1'b0, exp_b);
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    do_run(32'h0000_ABCD, 8'h7E, 8'h81, 20, 1'b1);
    exp_b++;
    recv(1, 1'b1, exp_b);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (bsy !== 1'b0 || v !== 1'b0) begin
        n_fail++;
        $display("FAIL no_restart: got busy=%b v=%b expected 0 0",
                 bsy, v);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    sel = 1'b0;
    do_run(32'h0102_0304, 8'h03, 8'h01, 7, 1'b0);
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      void'(q.pop_front());
      @(posedge clk); #1;
    end
    ack = 1'b0;
    n_chk++;
    if (v !== 1'b1 || by !== q[0]) begin
      n_fail++;
      $display("FAIL idx5_byte: got %b/%h expected 1/%h",
               v, by, q[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    chk_reset("mid_send_rst");
    q.delete();
    exp_a = 0;
    exp_b = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_run(32'h0A0B_0C0D, 8'h05, 8'h00, 30, 1'b0);
    exp_a++;
    recv(0, 1'b0, exp_a);
    n_chk++;
    if (b_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL b_cnt_after_rst: got %0d expected 0", b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_consecutive();
    test_random_ack();
    test_timeout();
    test_timeout_tie();
    test_back_to_back();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uut_perf_monitor.md
UUT_PERF_MONITOR -- requirements
Module: uut_perf_monitor

Interface
REQ-001 Parameter N_BLOCK_SIZE, default 32: width of uut_n_blocks (1..32).
REQ-002 Parameter SCLK_SPEED_SIZE, default 4: width of uut_sclk_speed (1..8).
REQ-003 Parameter CMD18_SIZE, default 1: width of uut_cmd18 (1..8).
REQ-004 Parameter TIMEOUT_CYCLES, default 32'hFFFF_FFFE: run-length limit in clk cycles (must be >= 1).
REQ-005 Ports: clk in 1, single clock, all logic on rising edge; reset is asynchronous and active-low.
REQ-006 Ports: rst in 1, asynchronous active-low reset.
REQ-007 Ports: uut_start in 1, UUT run start (level, sampled).
REQ-008 Ports: uut_finish in 1, UUT run completion (level, sampled).
REQ-009 Ports: uut_n_blocks in N_BLOCK_SIZE, uut_sclk_speed in SCLK_SPEED_SIZE, uut_cmd18 in CMD18_SIZE: run parameters.
REQ-010 Ports: rec_valid out 1, rec_byte out 8, rec_last out 1, rec_ack in 1: result byte stream to the SD-write FSM.
REQ-011 Ports: busy out 1 (state != IDLE), run_count out 16 (completed records).

Function
REQ-012 States: IDLE, RUN, SEND; no other reachable states.
REQ-013 IDLE: uut_start sampled high at cycle t0 -> capture n_blocks/sclk_speed/cmd18, clear status, enter RUN.
REQ-014 RUN: uut_finish sampled high at cycle t1 -> cycles = t1 - t0 (start and finish in consecutive cycles gives 1), enter SEND.
REQ-015 RUN: elapsed count reaching TIMEOUT_CYCLES without finish -> cycles = TIMEOUT_CYCLES, status bit0 (timeout) = 1, enter SEND.
REQ-016 Finish and timeout in the same cycle: finish wins, timeout bit stays 0.
REQ-017 uut_start while in RUN or SEND is ignored, not buffered; captured parameters stay constant until next IDLE start.
REQ-018 Record = 12 bytes, index 0..11: 0xA5; status {6'b0, 1'b0, timeout}; n_blocks zero-extended to 32 bits big-endian (4 bytes); sclk_speed zero-extended to 8; cmd18 zero-extended to 8; cycles 32-bit big-endian (4 bytes).
REQ-019 SEND: rec_valid = 1, rec_byte = record[idx], rec_last = (idx == 11); idx starts at 0 on SEND entry.
REQ-020 Handshake: byte transfers on cycle with rec_valid && rec_ack; idx increments next cycle; rec_byte/rec_last stable while rec_valid && !rec_ack.
REQ-021 rec_ack outside SEND is ignored.
REQ-022 Transfer of idx 11 -> run_count += 1 (wraps 0xFFFF -> 0x0000), enter IDLE next cycle, rec_valid low.
REQ-023 Zero combinational path from rec_ack to rec_valid/rec_byte; all outputs registered or decoded from state/idx only.

Reset
REQ-024 rst low, at any time, asynchronously forces: IDLE, rec_valid 0, rec_byte 0x00, rec_last 0, busy 0, run_count 0, idx 0, cycles 0, status 0.
REQ-025 Reset mid-RUN or mid-SEND discards the partial record; after release, module waits for a new uut_start in IDLE.

Structure
REQ-026 Package perf_pkg holds state enum, REC_LEN = 12, REC_MAGIC = 8'hA5, status bit indices, and default parameter widths.
REQ-027 One sub-module perf_record_serializer: holds the 12-byte record, idx, and the valid/ack/last logic; the top holds the FSM and cycle counter.

Verification
REQ-028 Start at t0, finish at t0+1000, rec_ack held 1 -> 12 bytes on consecutive cycles: A5 00 <nblk BE> <spd> <cmd> 00 00 03 E8, rec_last on 12th, run_count 1.
REQ-029 TIMEOUT_CYCLES = 50, finish never asserted -> status byte 0x01, cycles bytes 00 00 00 32.
REQ-030 TIMEOUT_CYCLES = 50, finish at exactly the 50th cycle -> status 0x00, cycles 0x32.
REQ-031 rec_ack toggled randomly 30% duty -> byte sequence identical to REQ-028; rec_byte stable during every stall cycle.
REQ-032 rst low during SEND idx 5 -> all outputs at reset values immediately; next run emits a full record starting with 0xA5; run_count 1.
REQ-033 uut_start re-pulsed during RUN and during SEND -> no restart, cycles unchanged, exactly one record per IDLE start.
